// File: rtl/arrow_spawner_if.sv
// Play control in, row-advance tick and row-1 arrow pattern out.
// The spawner is the master; the playfield row stages are the slave.
interface arrow_spawner_if;
    logic       play;
    logic       is10;
    logic [3:0] num;
    logic [7:0] arrowCount;
    logic       done;

    modport master (input play, output is10, num, arrowCount, done);
    modport slave  (output play, input is10, num, arrowCount, done);
endinterface

// File: rtl/arrow_spawner.sv
// Top-of-column arrow source: row-advance tick plus pseudo-random, spaced
// arrow patterns for a fixed-length song, followed by a drain period.
//
// state   | meaning
// S_IDLE  | waiting for play; tick counter held at 0
// S_RUN   | spawning arrows on every tick until SONG_LEN arrows are out
// S_DRAIN | empty ticks so the last arrows fall off the screen
// S_DONE  | song finished, done high; dropping play returns to IDLE
module arrow_spawner #(
    parameter int         TICK_DIV    = 10,
    parameter logic [7:0] SEED        = 8'hA5,
    parameter int         MIN_GAP     = 1,
    parameter int         SONG_LEN    = 32,
    parameter int         DRAIN_TICKS = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    arrow_spawner_if.master bus
);
    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0]    GAP_INIT  = 8'(MIN_GAP);
    localparam logic [7:0]    SONG_END  = 8'(SONG_LEN);
    localparam logic [7:0]    DRAIN_END = 8'(DRAIN_TICKS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        r_state;
    logic [TW-1:0] r_tick;
    logic [7:0]    r_lfsr;
    logic [7:0]    r_gap;
    logic [3:0]    r_num;
    logic [7:0]    r_count;
    logic [7:0]    r_drain;
    logic          r_done;

    logic w_active;
    logic w_is10;
    logic w_fb;

    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_is10   = w_active && bus.play && (r_tick == TICK_LAST);
    assign w_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_lfsr  <= SEED;
            r_gap   <= GAP_INIT;
            r_num   <= '0;
            r_count <= '0;
            r_drain <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tick <= '0;
                    if (bus.play) r_state <= S_RUN;
                end
                S_RUN, S_DRAIN: begin
                    // play low freezes everything, including the tick phase
                    if (bus.play) begin
                        if (w_is10) begin
                            r_tick <= '0;
                            if (r_state == S_RUN) begin
                                r_lfsr <= {r_lfsr[6:0], w_fb};
                                if (r_gap < GAP_INIT) begin
                                    r_num <= '0;
                                    r_gap <= r_gap + 8'd1;
                                end else if (r_lfsr[4]) begin
                                    r_num   <= 4'b0001 << r_lfsr[1:0];
                                    r_gap   <= '0;
                                    r_count <= r_count + 8'd1;
                                    if (r_count + 8'd1 == SONG_END) begin
                                        r_state <= S_DRAIN;
                                        r_drain <= '0;
                                    end
                                end else begin
                                    r_num <= '0;
                                end
                            end else begin
                                r_num   <= '0;
                                r_drain <= r_drain + 8'd1;
                                if (r_drain + 8'd1 == DRAIN_END) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end
                            end
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_tick <= '0;
                    // LFSR deliberately keeps running state so the next song differs
                    if (!bus.play) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                        r_count <= '0;
                        r_gap   <= GAP_INIT;
                        r_num   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.is10       = w_is10;
    assign bus.num        = r_num;
    assign bus.arrowCount = r_count;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_arrow_spawner.sv
// Self-checking bench for arrow_spawner: directed song scenarios followed by
// randomized play/reset, every cycle compared against a song-level model.
module tb_arrow_spawner;
    localparam int         TD   = 4;
    localparam logic [7:0] SEED = 8'hA5;
    localparam int         MG   = 2;
    localparam int         SL   = 3;
    localparam int         DT   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arrow_spawner_if bus();

    arrow_spawner #(
        .TICK_DIV(TD), .SEED(SEED), .MIN_GAP(MG), .SONG_LEN(SL), .DRAIN_TICKS(DT)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // song-level model: 0 idle, 1 run, 2 drain, 3 done
    int         m_mode;
    int         m_phase;
    logic [7:0] m_lfsr;
    int         m_gap;
    int         m_cnt;
    int         m_drain_left;
    logic [3:0] m_num;

    bit         armed      = 1'b0;
    bit         prev_valid = 1'b0;
    bit         prev_rst   = 1'b0;
    logic [3:0] prev_num;
    logic       prev_is10;

    logic       o_is10;
    logic [3:0] o_num;
    logic [7:0] o_cnt;
    logic       o_done;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_lfsr = SEED; m_gap = MG;
        m_cnt = 0; m_drain_left = 0; m_num = 4'd0;
    endtask

    task automatic model_tick();
        if (m_mode == 1) begin
            if (m_gap < MG) begin
                m_num = 4'd0;
                m_gap++;
            end else if (m_lfsr[4]) begin
                m_num = 4'd1 << m_lfsr[1:0];
                m_gap = 0;
                m_cnt++;
                if (m_cnt == SL) begin
                    m_mode = 2;
                    m_drain_left = DT;
                end
            end else begin
                m_num = 4'd0;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end else begin
            m_num = 4'd0;
            m_drain_left--;
            if (m_drain_left == 0) m_mode = 3;
        end
    endtask

    task automatic model_step(input bit p, input bit r);
        if (r) model_reset();
        else if (m_mode == 0) begin
            if (p) m_mode = 1;
        end else if (m_mode == 3) begin
            if (!p) begin
                m_mode = 0; m_cnt = 0; m_gap = MG; m_num = 4'd0;
            end
        end else if (p) begin
            m_phase = (m_phase + 1) % TD;
            if (m_phase == 0) model_tick();
        end
    endtask

    task automatic compare(input bit p);
        bit exp_is10;
        exp_is10 = (m_mode == 1 || m_mode == 2) && p && (m_phase == TD - 1);
        check("is10", o_is10, exp_is10);
        check("num", o_num, m_num);
        check("arrowCount", o_cnt, m_cnt);
        check("done", o_done, m_mode == 3);
        check("num_onehot", $countones(o_num) <= 1, 1);
        check("cnt_bound", o_cnt <= SL, 1);
        if (prev_valid && !prev_rst)
            check("num_glitch", (o_num !== prev_num) && !prev_is10, 0);
    endtask

    task automatic cyc(input bit p, input bit r);
        @(negedge clk);
        bus.play = p;
        rst      = r;
        #1;
        o_is10 = bus.is10;
        o_num  = bus.num;
        o_cnt  = bus.arrowCount;
        o_done = bus.done;
        if (armed) compare(p);
        prev_num   = o_num;
        prev_is10  = o_is10;
        prev_rst   = r;
        prev_valid = armed;
        @(posedge clk);
        model_step(p, r);
        if (r) armed = 1'b1;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         drain_ticks;
        logic [3:0] held;

        rst = 1'b1;
        bus.play = 1'b0;
        model_reset();
        cyc(0, 1);
        cyc(0, 1);
        cyc(0, 0);
        check("rst_num", o_num, 4'd0);
        check("rst_cnt", o_cnt, 8'd0);
        check("rst_done", o_done, 1'b0);
        check("rst_is10", o_is10, 1'b0);

        // first ticks from seed 0xA5: ticks 1 and 2 empty, tick 3 spawns 4'b0010
        cyc(1, 0);
        for (int i = 1; i <= 13; i++) begin
            cyc(1, 0);
            check("tick_pos", o_is10, (i % 4) == 0);
            if (i == 4)  check("model_lfsr_t1", m_lfsr, 8'h4A);
            if (i == 8)  check("model_lfsr_t2", m_lfsr, 8'h95);
            if (i == 12) check("model_lfsr_t3", m_lfsr, 8'h2A);
            if (i == 5 || i == 9) check("num_early", o_num, 4'd0);
            if (i == 13) begin
                check("num_first_arrow", o_num, 4'b0010);
                check("cnt_first_arrow", o_cnt, 8'd1);
            end
        end

        // pause for 7 cycles with the tick counter at 2
        n = 0;
        while (!((m_mode == 1 || m_mode == 2) && m_phase == 2) && n < 200) begin
            cyc(1, 0);
            n++;
        end
        check("pause_reach", n < 200, 1);
        held = m_num;
        for (int k = 0; k < 7; k++) begin
            cyc(0, 0);
            check("pause_is10", o_is10, 1'b0);
            check("pause_num", o_num, held);
        end
        cyc(1, 0);
        check("resume_is10_a", o_is10, 1'b0);
        cyc(1, 0);
        check("resume_is10_b", o_is10, 1'b1);

        // run the song to the end and count drain ticks
        n = 0;
        drain_ticks = 0;
        o_done = 1'b0;
        while (o_done !== 1'b1 && n < 3000) begin
            cyc(1, 0);
            if (o_cnt == SL && o_done === 1'b0 && o_is10 === 1'b1) drain_ticks++;
            n++;
        end
        check("done_reach", n < 3000, 1);
        check("drain_ticks", drain_ticks, DT);
        check("done_cnt", o_cnt, SL);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0);
            check("done_is10", o_is10, 1'b0);
            check("done_hold", o_done, 1'b1);
            check("done_num", o_num, 4'd0);
        end
        cyc(0, 0);
        cyc(0, 0);
        check("idle_cnt", o_cnt, 8'd0);
        check("idle_done", o_done, 1'b0);

        // reset while draining, with play held high
        n = 0;
        while (m_mode != 2 && n < 3000) begin
            cyc(1, 0);
            n++;
        end
        check("drain_reach", n < 3000, 1);
        cyc(1, 1);
        cyc(1, 0);
        check("drst_num", o_num, 4'd0);
        check("drst_cnt", o_cnt, 8'd0);
        check("drst_done", o_done, 1'b0);
        check("drst_is10", o_is10, 1'b0);
        check("drst_model_lfsr", m_lfsr, SEED);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 0);
            check("drst_tick_pos", o_is10, i == 4);
        end

        // randomized play with occasional reset
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 99) < 85, $urandom_range(0, 299) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
